req_arbiter: RTL and testbench

// - Sequential 8-way arbiter sharing one resource between requesters; priority-encoder core plus grant FSM.
// - Supports fixed priority (highest index wins) or round-robin with a max-hold timeout.
// - Registered one-hot grant, encoded ID and valid flag feed the downstream mux/resource.

---
 rtl/req_arbiter.sv | 121 ++++++++++++
 tb/tb_req_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// 8-way request arbiter: fixed-priority or round-robin with hold timeout.
// Registered one-hot grant, encoded id and valid flag.
module req_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 4,
  localparam int IW = $clog2(N_REQ),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             v
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [IW-1:0]    last;

  logic [IW-1:0]    hi_win;
  logic [IW-1:0]    rr_win;
  logic [IW-1:0]    rr_oth;
  logic [IW-1:0]    any_win;
  logic [N_REQ-1:0] others;
  logic             owner_req;
  logic             timeout;

  // Round-robin pick: first set bit scanning down from `from`-1, wrapping.
  function automatic logic [IW-1:0] pick_rr(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    from
  );
    logic [IW-1:0] w;
    int            idx;
    w = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(from) + N_REQ - k) % N_REQ;
      if (r[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IW-1:0] i
  );
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
    hi_win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) hi_win = IW'(i);
    end
  end

  assign others    = req & ~gnt;
  assign rr_win    = pick_rr(req, last);
  assign rr_oth    = pick_rr(others, last);
  assign any_win   = mode ? rr_win : hi_win;
  assign owner_req = req[gnt_id];
  assign timeout   = mode && (hold_cnt == HW'(MAX_HOLD))
                     && (|others);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      v        <= 1'b0;
      hold_cnt <= '0;
      last     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && (|req)) begin
            state    <= GRANT;
            gnt      <= onehot(any_win);
            gnt_id   <= any_win;
            v        <= 1'b1;
            hold_cnt <= HW'(1);
            last     <= any_win;
          end
        end
        GRANT: begin
          if (!en) begin
            state    <= IDLE;
            gnt      <= '0;
            v        <= 1'b0;
            hold_cnt <= '0;
          end else if (!owner_req) begin
            if (|req) begin
              gnt      <= onehot(any_win);
              gnt_id   <= any_win;
              hold_cnt <= HW'(1);
              last     <= any_win;
            end else begin
              state    <= IDLE;
              gnt      <= '0;
              v        <= 1'b0;
              hold_cnt <= '0;
            end
          end else if (timeout) begin
            gnt      <= onehot(rr_oth);
            gnt_id   <= rr_oth;
            hold_cnt <= HW'(1);
            last     <= rr_oth;
          end else if (hold_cnt != HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter: directed steps plus random traffic against
// an integer-level reference model of the arbitration rules.
module tb_req_arbiter;

  localparam int N   = 8;
  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       v;

  int tests = 0;
  int fails = 0;

  // reference state: owner index or -1 when nothing is granted
  int m_own, m_hc, m_last, m_id;

  req_arbiter #(.N_REQ(N), .MAX_HOLD(MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .req(req), .gnt(gnt), .gnt_id(gnt_id), .v(v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hi_pick(input logic [7:0] r);
    for (int j = N - 1; j >= 0; j--) if (r[j]) return j;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [7:0] r, input int from);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (from - k + N) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_hc = 0; m_last = 0; m_id = 0;
  endtask

  task automatic take(input int w);
    m_own = w; m_hc = 1; m_last = w; m_id = w;
  endtask

  task automatic model_update();
    logic [7:0] oth;
    if (m_own < 0) begin
      if (en && req != 0) take(mode ? rr_pick(req, m_last) : hi_pick(req));
    end else if (!en) begin
      m_own = -1; m_hc = 0;
    end else if (!req[m_own]) begin
      if (req != 0) take(mode ? rr_pick(req, m_last) : hi_pick(req));
      else begin m_own = -1; m_hc = 0; end
    end else begin
      oth = req & ~(8'(1) << m_own);
      if (mode && m_hc == MAX && oth != 0) take(rr_pick(oth, m_last));
      else if (m_hc < MAX) m_hc++;
    end
  endtask

  task automatic check_model(input string tag);
    int eg;
    eg = (m_own < 0) ? 0 : (1 << m_own);
    chk({tag, ".gnt"}, int'(gnt), eg);
    chk({tag, ".id"}, int'(gnt_id), m_id);
    chk({tag, ".v"}, int'(v), (m_own >= 0) ? 1 : 0);
    chk({tag, ".onehot"}, int'($countones(gnt) <= 1), 1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.gnt", int'(gnt), 0);
    chk("arst.id", int'(gnt_id), 0);
    chk("arst.v", int'(v), 0);
    rst = 1'b0;
  endtask

  int seq[6] = '{5, 4, 2, 1, 0, 5};

  initial begin
    model_reset();
    #2;
    chk("reset.gnt", int'(gnt), 0);
    chk("reset.v", int'(v), 0);
    chk("reset.id", int'(gnt_id), 0);
    @(negedge clk);
    rst = 1'b0;

    // fixed priority, then release with no bubble
    mode = 1'b0; en = 1'b1; req = 8'b0100_0100;
    step("fix1");
    chk("fix1.k", int'(gnt), 8'h40);
    req = 8'b0000_0100;
    step("fix2");
    chk("fix2.k", int'(gnt_id), 2);
    chk("fix2.kv", int'(v), 1);

    // async reset mid-grant, then first RR grant is 7
    req = 8'hFF;
    step("pre_rst");
    #2;
    pulse_reset();
    mode = 1'b1;
    step("rr_first");
    chk("rr_first.k", int'(gnt_id), 7);

    // round-robin rotation with timeout
    #2;
    pulse_reset();
    req = 8'b0011_0111;
    for (int c = 0; c < 24; c++) begin
      step("rr");
      chk("rr.seq", int'(gnt_id), seq[c / 4]);
    end

    // enable gating
    req = 8'h00;
    step("idle");
    en = 1'b0; req = 8'h80;
    for (int c = 0; c < 3; c++) begin
      step("en0");
      chk("en0.v", int'(v), 0);
    end
    en = 1'b1;
    step("en1");
    chk("en1.k", int'(gnt_id), 7);
    en = 1'b0;
    step("en_drop");
    chk("en_drop.g", int'(gnt), 0);
    chk("en_drop.id", int'(gnt_id), 7);

    // lone requester in RR mode keeps the grant
    en = 1'b1; mode = 1'b1; req = 8'h80;
    for (int c = 0; c < 10; c++) begin
      step("lone");
      chk("lone.k", int'(gnt_id), 7);
    end
    req = 8'h00;
    step("lone_rel");
    chk("lone_rel.v", int'(v), 0);

    // fixed mode never times out
    mode = 1'b0; req = 8'b1000_0001;
    for (int c = 0; c < 10; c++) begin
      step("starve");
      chk("starve.k", int'(gnt_id), 7);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(3))
        0: req = 8'($urandom);
        1: req = 8'($urandom) & 8'($urandom);
        2: req = req;
        default: req = req & ~(8'(1) << gnt_id);
      endcase
      if ($urandom_range(9) == 0) mode = ~mode;
      en = ($urandom_range(15) != 0);
      step("rand");
      if ($urandom_range(99) == 0) begin
        #2;
        pulse_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
